lcd_capture: RTL and testbench

LCD_CAPTURE -- requirements
Module: lcd_capture

---
 rtl/lcd_capture.sv | 114 +++++++++++
 tb/tb_lcd_capture.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_capture.sv
// Captures a sampled LCD pixel stream into framebuffer write strobes.
// The pixel clock is edge-detected in the clk domain; sync edges re-align the x/y raster position.
//
// state    | meaning
// UNSYNCED | no vsync rise seen since reset; pixels ignored
// ACTIVE   | raster position valid; pixels written or flagged as overrun
module lcd_capture #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 144
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lcd_clk,
  input  logic        lcd_ena,
  input  logic        lcd_hsync,
  input  logic        lcd_vsync,
  input  logic [1:0]  lcd_color,
  input  logic        err_clear,
  output logic [14:0] fb_addr,
  output logic [1:0]  fb_data,
  output logic        fb_write,
  output logic        frame_done,
  output logic        synced,
  output logic        err_overrun
);

  typedef enum logic {UNSYNCED = 1'b0, ACTIVE = 1'b1} state_t;

  localparam logic [7:0]  W_X   = 8'(WIDTH);
  localparam logic [7:0]  H_Y   = 8'(HEIGHT);
  localparam logic [14:0] W_ROW = 15'(WIDTH);

  state_t      state, state_nxt;
  logic        lcd_clk_q, hs_q, vs_q;
  logic        strobe, vs_rise, hs_rise;
  logic [7:0]  x, y, x_sync, y_sync;
  logic [14:0] row_base, base_sync;
  logic        pix_evt, pix_ok, pix_ovr;

  assign strobe  = lcd_clk & ~lcd_clk_q;
  assign vs_rise = strobe & lcd_vsync & ~vs_q;
  assign hs_rise = strobe & lcd_hsync & ~hs_q;

  always_ff @(posedge clk) begin
    if (rst) state <= UNSYNCED;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (vs_rise) state_nxt = ACTIVE;
  end

  always_comb begin
    synced = (state == ACTIVE);
  end

  // Raster position after applying any sync edge of this strobe, so a
  // coincident pixel lands at the re-aligned position.
  always_comb begin
    x_sync    = x;
    y_sync    = y;
    base_sync = row_base;
    if (vs_rise) begin
      x_sync    = '0;
      y_sync    = '0;
      base_sync = '0;
    end else if (hs_rise && state == ACTIVE) begin
      x_sync = '0;
      if (x != 8'd0 && y < H_Y) begin
        y_sync    = y + 8'd1;
        base_sync = row_base + W_ROW;
      end
    end
  end

  assign pix_evt = strobe & lcd_ena & (state_nxt == ACTIVE);
  assign pix_ok  = pix_evt & (x_sync < W_X) & (y_sync < H_Y);
  assign pix_ovr = pix_evt & ~pix_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      lcd_clk_q   <= 1'b1;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      x           <= '0;
      y           <= '0;
      row_base    <= '0;
      fb_addr     <= '0;
      fb_data     <= '0;
      fb_write    <= 1'b0;
      frame_done  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      lcd_clk_q <= lcd_clk;
      if (strobe) begin
        hs_q <= lcd_hsync;
        vs_q <= lcd_vsync;
      end
      x        <= pix_ok ? x_sync + 8'd1 : x_sync;
      y        <= y_sync;
      row_base <= base_sync;
      fb_write <= pix_ok;
      if (pix_ok) begin
        fb_addr <= base_sync + {7'd0, x_sync};
        fb_data <= lcd_color;
      end
      frame_done <= vs_rise && (state == ACTIVE) && (y == H_Y);
      if (pix_ovr)        err_overrun <= 1'b1;
      else if (err_clear) err_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lcd_capture.sv
// Self-checking bench for lcd_capture: vector table, directed corner sequences
// and randomized strobes against a raster-position reference model.
module tb_lcd_capture;
  localparam int WIDTH  = 160;
  localparam int HEIGHT = 144;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lcd_clk = 1'b1;
  logic        lcd_ena = 1'b0;
  logic        lcd_hsync = 1'b0;
  logic        lcd_vsync = 1'b0;
  logic [1:0]  lcd_color = 2'd0;
  logic        err_clear = 1'b0;
  logic [14:0] fb_addr;
  logic [1:0]  fb_data;
  logic        fb_write, frame_done, synced, err_overrun;

  lcd_capture #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .clk(clk), .rst(rst), .lcd_clk(lcd_clk), .lcd_ena(lcd_ena),
    .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_color(lcd_color),
    .err_clear(err_clear), .fb_addr(fb_addr), .fb_data(fb_data),
    .fb_write(fb_write), .frame_done(frame_done), .synced(synced),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: raster position as plain integers, address = y*WIDTH+x
  bit m_sync, m_err, m_phs, m_pvs, m_wr, m_fd;
  int m_x, m_y, m_addr, m_data;

  int wr_count, fd_count, last_addr;

  typedef struct {
    logic ena, hs, vs;
    logic [1:0] col;
    logic wr;
    int addr;
    int data;
    logic syn, err;
  } vec_t;
  vec_t vt[12];

  function automatic vec_t mk(input logic ena, hs, vs, input logic [1:0] col,
                              input logic wr, input int addr, input int data,
                              input logic syn, err);
    vec_t v;
    v.ena = ena; v.hs = hs; v.vs = vs; v.col = col; v.wr = wr;
    v.addr = addr; v.data = data; v.syn = syn; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sync = 0; m_err = 0; m_phs = 1; m_pvs = 1; m_wr = 0; m_fd = 0;
    m_x = 0; m_y = 0; m_addr = 0; m_data = 0;
  endtask

  task automatic model_step(input bit ena, hs, vs, input int col, input bit clr);
    bit vr, hr, ovr;
    vr = vs && !m_pvs;
    hr = hs && !m_phs;
    m_pvs = vs; m_phs = hs;
    m_wr = 0; m_fd = 0; ovr = 0;
    if (vr) begin
      m_fd = m_sync && (m_y == HEIGHT);
      m_sync = 1; m_x = 0; m_y = 0;
    end else if (hr && m_sync) begin
      if (m_x != 0 && m_y < HEIGHT) m_y++;
      m_x = 0;
    end
    if (ena && m_sync) begin
      if (m_x < WIDTH && m_y < HEIGHT) begin
        m_wr = 1; m_addr = m_y * WIDTH + m_x; m_data = col; m_x++;
      end else ovr = 1;
    end
    if (ovr) m_err = 1;
    else if (clr) m_err = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; lcd_clk = 1'b1; err_clear = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // one pixel-clock period: low cycle, then high cycle; outputs sampled after the strobe edge
  task automatic strobe(input logic ena, hs, vs, input logic [1:0] col, input logic clr);
    @(negedge clk);
    lcd_clk = 1'b0;
    @(negedge clk);
    chk("idle_write", int'(fb_write), 0);
    chk("idle_frame_done", int'(frame_done), 0);
    lcd_clk = 1'b1; lcd_ena = ena; lcd_hsync = hs; lcd_vsync = vs;
    lcd_color = col; err_clear = clr;
    model_step(ena, hs, vs, int'(col), clr);
    @(posedge clk);
    #1;
    err_clear = 1'b0;
    chk("fb_write", int'(fb_write), int'(m_wr));
    chk("fb_addr", int'(fb_addr), m_addr);
    chk("fb_data", int'(fb_data), m_data);
    chk("frame_done", int'(frame_done), int'(m_fd));
    chk("synced", int'(synced), int'(m_sync));
    chk("err_overrun", int'(err_overrun), int'(m_err));
    if (fb_write) begin wr_count++; last_addr = int'(fb_addr); end
    if (frame_done) fd_count++;
  endtask

  task automatic clear_err();
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    m_err = 0;
    chk("err_clear", int'(err_overrun), 0);
  endtask

  initial begin
    vt[0]  = mk(1'b1, 1'b0, 1'b0, 2'd1, 1'b0,   0, 0, 1'b0, 1'b0);
    vt[1]  = mk(1'b1, 1'b0, 1'b1, 2'd3, 1'b1,   0, 3, 1'b1, 1'b0);
    vt[2]  = mk(1'b1, 1'b0, 1'b1, 2'd1, 1'b1,   1, 1, 1'b1, 1'b0);
    vt[3]  = mk(1'b1, 1'b0, 1'b0, 2'd2, 1'b1,   2, 2, 1'b1, 1'b0);
    vt[4]  = mk(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 160, 0, 1'b1, 1'b0);
    vt[5]  = mk(1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 161, 1, 1'b1, 1'b0);
    vt[6]  = mk(1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 162, 2, 1'b1, 1'b0);
    vt[7]  = mk(1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 162, 2, 1'b1, 1'b0);
    vt[8]  = mk(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 162, 2, 1'b1, 1'b0);
    vt[9]  = mk(1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 162, 2, 1'b1, 1'b0);
    vt[10] = mk(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 162, 2, 1'b1, 1'b0);
    vt[11] = mk(1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 320, 2, 1'b1, 1'b0);

    model_reset();
    wr_count = 0; fd_count = 0; last_addr = -1;

    // reset values
    do_reset();
    chk("rst_write", int'(fb_write), 0);
    chk("rst_addr", int'(fb_addr), 0);
    chk("rst_data", int'(fb_data), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_synced", int'(synced), 0);
    chk("rst_err", int'(err_overrun), 0);

    // vector table: unsynced pixel, vsync+pixel coincidence, hsync+pixel coincidence
    for (int i = 0; i < 12; i++) begin
      strobe(vt[i].ena, vt[i].hs, vt[i].vs, vt[i].col, 1'b0);
      chk("tbl_write", int'(fb_write), int'(vt[i].wr));
      chk("tbl_addr", int'(fb_addr), vt[i].addr);
      chk("tbl_data", int'(fb_data), vt[i].data);
      chk("tbl_synced", int'(synced), int'(vt[i].syn));
      chk("tbl_err", int'(err_overrun), int'(vt[i].err));
    end

    // pixels before any vsync rise are ignored
    do_reset();
    wr_count = 0;
    for (int i = 0; i < 8; i++) strobe(1'b1, 1'b0, 1'b0, 2'd3, 1'b0);
    chk("unsync_writes", wr_count, 0);
    chk("unsync_synced", int'(synced), 0);
    chk("unsync_err", int'(err_overrun), 0);

    // one line of color 2, then overrun on pixel 161
    strobe(1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    wr_count = 0;
    for (int i = 0; i < WIDTH; i++) strobe(1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
    chk("line_writes", wr_count, WIDTH);
    chk("line_last_addr", last_addr, WIDTH - 1);
    chk("line_err_before", int'(err_overrun), 0);
    strobe(1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
    chk("overrun_writes", wr_count, WIDTH);
    chk("overrun_err", int'(err_overrun), 1);
    strobe(1'b1, 1'b0, 1'b0, 2'd1, 1'b1);
    chk("set_beats_clear", int'(err_overrun), 1);
    clear_err();

    // pixel clock held high: exactly one strobe
    strobe(1'b1, 1'b1, 1'b0, 2'd3, 1'b0);
    chk("hold_first_write", int'(fb_write), 1);
    chk("hold_first_addr", int'(fb_addr), WIDTH);
    repeat (6) begin
      @(posedge clk);
      #1;
      chk("hold_no_write", int'(fb_write), 0);
    end

    // full frame, then vsync rise
    do_reset();
    strobe(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    strobe(1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    wr_count = 0; fd_count = 0;
    for (int ln = 0; ln < HEIGHT; ln++) begin
      for (int px = 0; px < WIDTH; px++)
        strobe(1'b1, 1'b0, 1'b0, 2'($urandom_range(0, 3)), 1'b0);
      strobe(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    end
    strobe(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    strobe(1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    chk("frame_writes", wr_count, WIDTH * HEIGHT);
    chk("frame_last_addr", last_addr, 23039);
    chk("frame_done_count", fd_count, 1);
    chk("frame_err", int'(err_overrun), 0);

    // reset at line 50 with vsync held high
    for (int ln = 0; ln < 50; ln++) begin
      strobe(1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
      strobe(1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
    end
    strobe(1'b1, 1'b0, 1'b1, 2'd2, 1'b0);
    chk("line50_addr", int'(fb_addr), 50 * WIDTH);
    do_reset();
    wr_count = 0;
    for (int i = 0; i < 4; i++) strobe(1'b1, 1'b0, 1'b1, 2'd3, 1'b0);
    strobe(1'b1, 1'b0, 1'b0, 2'd3, 1'b0);
    chk("rst_mid_writes", wr_count, 0);
    chk("rst_mid_synced", int'(synced), 0);
    strobe(1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
    chk("resync_write", int'(fb_write), 1);
    chk("resync_addr", int'(fb_addr), 0);

    // randomized strobes against the model
    do_reset();
    for (int i = 0; i < 3000; i++)
      strobe(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 24) == 0),
             logic'($urandom_range(0, 399) == 0), 2'($urandom_range(0, 3)),
             logic'($urandom_range(0, 49) == 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
